// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared widths, NOP encoding and per-cycle operating modes for the fetch stage
package if_stage_pkg;

    localparam int N_DEFAULT          = 32;
    localparam int IMEM_WORDS_DEFAULT = 64;
    localparam logic [31:0] NOP       = 32'h0000_0000;

    // Per-cycle operating mode of the fetch stage; decoded fresh every cycle, never stored
    typedef enum logic [1:0] {
        MODE_RESET,
        MODE_RUN,
        MODE_STALL,
        MODE_FLUSH
    } mode_e;

endpackage

// File: rtl/InstructionMemory.sv
// InstructionMemory: combinational ROM indexed by word address; words past the end read as NOP
import if_stage_pkg::*;

module InstructionMemory #(
    parameter int AW         = 30,
    parameter int IMEM_WORDS = IMEM_WORDS_DEFAULT,
    parameter logic [IMEM_WORDS*32-1:0] IMEM_INIT = '0
) (
    input  logic [AW-1:0] addr,
    output logic [31:0]   data
);

    localparam int IW = $clog2(IMEM_WORDS);

    // Program image, elaborated from the hex file contents handed down as IMEM_INIT
    logic [31:0] rom [IMEM_WORDS];

    for (genvar i = 0; i < IMEM_WORDS; i++) begin : g_rom
        assign rom[i] = IMEM_INIT[i*32 +: 32];
    end

    logic in_range;

    // Addresses beyond the last word return NOP rather than aliasing back into the image
    always_comb begin
        in_range = addr < AW'(IMEM_WORDS);
        data     = in_range ? rom[addr[IW-1:0]] : NOP;
    end

endmodule

// File: rtl/if_stage.sv
// if_stage: PC register, instruction fetch and IF/ID register; IF_PERF_CNT_EN enables the fetch/stall/flush counters
import if_stage_pkg::*;

module if_stage #(
    parameter int N          = N_DEFAULT,
    parameter int IMEM_WORDS = IMEM_WORDS_DEFAULT,
    parameter logic [IMEM_WORDS*32-1:0] IMEM_INIT = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         freezeIn,
    input  logic         branchTakenIn,
    input  logic [N-1:0] branchAddrIn,
    output logic [N-1:0] PCOut,
    output logic [N-1:0] instructionOut,
    output logic         validOut,
    output logic [N-1:0] fetchCntOut,
    output logic [N-1:0] stallCntOut,
    output logic [N-1:0] flushCntOut
);

    logic [N-1:0] pc;
    logic [N-1:0] pc_plus4;
    logic [31:0]  fetch_word;
    mode_e        mode;

    // Low two PC bits never reach the ROM; they are kept only in the PC itself
    InstructionMemory #(
        .AW         (N - 2),
        .IMEM_WORDS (IMEM_WORDS),
        .IMEM_INIT  (IMEM_INIT)
    ) u_imem (
        .addr (pc[N-1:2]),
        .data (fetch_word)
    );

    // Mode priority: reset, then branch flush (beats a simultaneous freeze), then stall, else run
    always_comb begin
        pc_plus4 = pc + N'(4);
        mode     = !rst          ? MODE_RESET :
                   branchTakenIn ? MODE_FLUSH :
                   freezeIn      ? MODE_STALL : MODE_RUN;
    end

    // PC and IF/ID register share one mode decode so they can never disagree
    always_ff @(posedge clk) begin
        unique case (mode)
            MODE_RESET: begin
                pc             <= '0;
                PCOut          <= '0;
                instructionOut <= N'(NOP);
                validOut       <= 1'b0;
            end
            MODE_FLUSH: begin
                pc             <= branchAddrIn;
                PCOut          <= '0;
                instructionOut <= N'(NOP);
                validOut       <= 1'b0;
            end
            MODE_STALL: begin
                pc             <= pc;
                PCOut          <= PCOut;
                instructionOut <= instructionOut;
                validOut       <= validOut;
            end
            MODE_RUN: begin
                pc             <= pc_plus4;
                PCOut          <= pc_plus4;
                instructionOut <= N'(fetch_word);
                validOut       <= 1'b1;
            end
        endcase
    end

`ifdef IF_PERF_CNT_EN
    logic [N-1:0] fetch_cnt;
    logic [N-1:0] stall_cnt;
    logic [N-1:0] flush_cnt;

    // Each counter tracks one mode; a freeze overridden by a branch counts only as a flush
    always_ff @(posedge clk) begin
        if (mode == MODE_RESET) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            fetch_cnt <= fetch_cnt + N'(mode == MODE_RUN);
            stall_cnt <= stall_cnt + N'(mode == MODE_STALL);
            flush_cnt <= flush_cnt + N'(mode == MODE_FLUSH);
        end
    end

    assign fetchCntOut = fetch_cnt;
    assign stallCntOut = stall_cnt;
    assign flushCntOut = flush_cnt;
`else
    assign fetchCntOut = '0;
    assign stallCntOut = '0;
    assign flushCntOut = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed plus random stimulus against a per-cycle reference model, checked through a scoreboard queue
module tb_if_stage;

    localparam int N          = 32;
    localparam int IMEM_WORDS = 64;

    function automatic logic [IMEM_WORDS*32-1:0] make_image();
        logic [IMEM_WORDS*32-1:0] v;
        v = '0;
        for (int i = 0; i < IMEM_WORDS; i++)
            v[i*32 +: 32] = 32'(i) * 32'h0101_0101 + 32'h1234_5013;
        return v;
    endfunction

    localparam logic [IMEM_WORDS*32-1:0] IMG = make_image();

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         freezeIn = 1'b0;
    logic         branchTakenIn = 1'b0;
    logic [N-1:0] branchAddrIn = '0;
    logic [N-1:0] PCOut, instructionOut, fetchCntOut, stallCntOut, flushCntOut;
    logic         validOut;

    if_stage #(.N(N), .IMEM_WORDS(IMEM_WORDS), .IMEM_INIT(IMG)) dut (
        .clk            (clk),
        .rst            (rst),
        .freezeIn       (freezeIn),
        .branchTakenIn  (branchTakenIn),
        .branchAddrIn   (branchAddrIn),
        .PCOut          (PCOut),
        .instructionOut (instructionOut),
        .validOut       (validOut),
        .fetchCntOut    (fetchCntOut),
        .stallCntOut    (stallCntOut),
        .flushCntOut    (flushCntOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pcout;
        logic        valid;
        logic [31:0] fc;
        logic [31:0] sc;
        logic [31:0] xc;
    } exp_t;

    exp_t q[$];
    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] rom [IMEM_WORDS];
    logic [31:0] m_pc, m_instr, m_pcout, m_fc, m_sc, m_xc;
    logic        m_valid;

    function automatic logic [31:0] fetch(input logic [31:0] a);
        return (a >> 2) < 32'(IMEM_WORDS) ? rom[a[7:2]] : 32'h0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: drive inputs, let the edge happen, advance the model and queue its view
    task automatic step(input logic r, input logic f, input logic b, input logic [31:0] a);
        exp_t e;
        rst = r;
        freezeIn = f;
        branchTakenIn = b;
        branchAddrIn = a;
        @(posedge clk);
        if (!r) begin
            m_pc = 0; m_instr = 0; m_pcout = 0; m_valid = 0;
            m_fc = 0; m_sc = 0; m_xc = 0;
        end else if (b) begin
            m_instr = 0; m_pcout = 0; m_valid = 0; m_pc = a; m_xc++;
        end else if (f) begin
            m_sc++;
        end else begin
            m_instr = fetch(m_pc); m_pcout = m_pc + 4; m_valid = 1; m_pc = m_pc + 4; m_fc++;
        end
        e.instr = m_instr;
        e.pcout = m_pcout;
        e.valid = m_valid;
`ifdef IF_PERF_CNT_EN
        e.fc = m_fc; e.sc = m_sc; e.xc = m_xc;
`else
        e.fc = 0; e.sc = 0; e.xc = 0;
`endif
        q.push_back(e);
        #1;
    endtask

    // Monitor: outputs are sampled on the falling edge, half a cycle after the edge that produced them
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("instructionOut", instructionOut, e.instr);
            chk("PCOut", PCOut, e.pcout);
            chk("validOut", {31'b0, validOut}, {31'b0, e.valid});
            chk("fetchCntOut", fetchCntOut, e.fc);
            chk("stallCntOut", stallCntOut, e.sc);
            chk("flushCntOut", flushCntOut, e.xc);
        end
    end

    initial begin
        int w;
        for (int i = 0; i < IMEM_WORDS; i++) rom[i] = IMG[i*32 +: 32];
        m_pc = 0; m_instr = 0; m_pcout = 0; m_valid = 0; m_fc = 0; m_sc = 0; m_xc = 0;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 1, 32'h20);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 1, 32'h10);
        step(1, 0, 0, 0);
        step(1, 0, 1, 32'h22);
        step(1, 0, 0, 0);
        step(1, 0, 1, 32'(4 * IMEM_WORDS));
        step(1, 0, 0, 0);
        step(1, 0, 1, 32'hFFFF_FFFC);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 1, 32'h30);
        step(0, 1, 1, 32'h30);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        for (int c = 0; c < 2000; c++) begin
            logic [31:0] a;
            w = int'($urandom_range(0, 99));
            a = ($urandom_range(0, 9) == 0) ? $urandom
                                            : ((32'($urandom_range(0, IMEM_WORDS + 8)) << 2) | ($urandom & 32'h3));
            step(w >= 2, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0, a);
        end
        rst = 1'b1; freezeIn = 1'b1; branchTakenIn = 1'b0;
        for (int t = 0; t < 10 && q.size() > 0; t++) @(posedge clk);
        @(posedge clk);
        if (q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter N, default 32: datapath and PC width.
REQ-002 Parameter IMEM_WORDS, default 64: instruction memory depth in 32-bit words.
REQ-003 clk  input  1  rising-edge clock, sole clock.
REQ-004 rst  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-005 freezeIn  input  1  hazard stall; holds PC and IF/ID register.
REQ-006 branchTakenIn  input  1  branch resolved taken in EXE.
REQ-007 branchAddrIn  input  N  branch target byte address.
REQ-008 PCOut  output  N  registered PC+4 of the instruction in IF/ID (feeds decode PCIn).
REQ-009 instructionOut  output  N  registered instruction word (feeds decode instructionIn).
REQ-010 validOut  output  1  IF/ID holds a real fetched instruction.
REQ-011 fetchCntOut, stallCntOut, flushCntOut  output  N each  performance counters.

Function
REQ-012 PC register byte-addressed; instruction memory read combinational at word index PC[log2(IMEM_WORDS)+1:2].
REQ-013 PC address beyond IMEM_WORDS-1 words returns 32'h0000_0000.
REQ-014 Next PC: branchTakenIn=1 -> branchAddrIn; else freezeIn=1 -> hold; else PC+4.
REQ-015 PC+4 wraps modulo 2^N; no overflow flag.
REQ-016 PC bits [1:0] ignored for memory indexing; stored unchanged.
REQ-017 IF/ID update priority: rst low > branchTakenIn (flush) > freezeIn (hold) > load.
REQ-018 Flush: instructionOut <= 0, PCOut <= 0, validOut <= 0 on next edge.
REQ-019 Load: instructionOut <= imem[PC], PCOut <= PC+4, validOut <= 1.
REQ-020 Hold: IF/ID outputs and validOut unchanged.
REQ-021 branchTakenIn and freezeIn both high: branch wins for PC and IF/ID (flush); stall not counted.
REQ-022 Fetch-to-output latency: exactly one clk edge from PC value to instructionOut.
REQ-023 Branch penalty: first target instruction valid on instructionOut two edges after branchTakenIn sampled.
REQ-024 No other state machine: operating modes are RESET, RUN, STALL, FLUSH, selected per cycle by REQ-017.

Reset
REQ-025 On rst low at clk edge: PC <= 0, instructionOut <= 0, PCOut <= 0, validOut <= 0, all counters <= 0.
REQ-026 Reset mid-stall or mid-branch discards pending branch/freeze; first post-reset fetch is address 0.
REQ-027 Outputs change only at clk edges; no asynchronous path from rst.

Configuration
REQ-028 Macro IF_PERF_CNT_EN defined: fetchCntOut increments per load, stallCntOut per hold cycle, flushCntOut per flush; all wrap modulo 2^N.
REQ-029 IF_PERF_CNT_EN undefined: counter registers not synthesized; the three counter outputs tied to 0; all other behaviour identical.

Structure
REQ-030 Shared package holds N default, NOP encoding 32'h0000_0000, and IMEM_WORDS default.
REQ-031 One sub-module, InstructionMemory: combinational ROM, address in, word out, initialised from hex file.
REQ-032 PC register and IF/ID register reside in if_stage; no separate pipeline-register module.

Verification
REQ-033 Reset then 3 free-run cycles, imem[0..2]=A,B,C -> instructionOut A,B,C with PCOut 4,8,12; validOut 1 from first load.
REQ-034 freezeIn high 2 cycles while PC=8 -> PC stays 8, instructionOut/PCOut held; stallCntOut +2 when IF_PERF_CNT_EN defined.
REQ-035 branchTakenIn high, branchAddrIn=0x20 -> next edge validOut=0, instructionOut=0; following edge instructionOut=imem[8], PCOut=0x24.
REQ-036 branchTakenIn and freezeIn high together, branchAddrIn=0x10 -> flush, PC=0x10; stallCntOut unchanged, flushCntOut +1.
REQ-037 PC=4*IMEM_WORDS -> instructionOut=0, validOut=1; PC=0xFFFF_FFFC free-run -> PC wraps to 0.
REQ-038 rst low during freeze plus branch -> all outputs 0 next edge; after release first instructionOut=imem[0], PCOut=4.
